fft_stage_sequencer: RTL
========================

// Module: fft_stage_sequencer
// PURPOSE
//  Address/control sequencer for the 64-point radix-2 DIT FFT datapath.
//  Walks 6 stages x 32 butterflies and issues per butterfly:
//   - operand addresses A/B
//   - twiddle index
//   - 3-bit stage code STAGE, which drives S of the 8:1 per-stage select muxes.
//  Sits directly upstream of those muxes and of the butterfly unit.
// PARAMETERS
//  N_LOG2     6   log2(FFT points); addresses are N_LOG2 bits wide
//  SEL_WIDTH  3   width of STAGE (mux select); 2**SEL_WIDTH >= N_LOG2
// PORTS
//  CLK        in   1          clock, rising edge
//  RST_N      in   1          asynchronous reset, active-low
//  START      in   1          request one full FFT pass; sampled only in IDLE
//  STALL      in   1          downstream not ready; freezes the sequence
//  BUSY       out  1          high from first issue until DONE
//  VALID      out  1          ADDR_A/ADDR_B/TW_IDX/STAGE are a live butterfly
//  STAGE      out  SEL_WIDTH  current stage 0..N_LOG2-1 (mux select)
//  ADDR_A     out  N_LOG2     upper-leg operand address
//  ADDR_B     out  N_LOG2     lower-leg operand address (ADDR_A + span)
//  TW_IDX     out  N_LOG2-1   twiddle ROM index, 0..31
//  LAST_BF    out  1          qualifies VALID: last butterfly of current stage
//  DONE       out  1          one-cycle pulse after final butterfly issued
// BEHAVIOUR
//  Reset (RST_N=0, async): FSM=IDLE; all outputs and counters 0.
//  FSM states and transitions:
//   IDLE: START=1 -> RUN, counters stage=0, k=0; START=0 -> stay.
//   RUN: one butterfly per unstalled cycle; all outputs registered.
//   FIN: DONE=1 for exactly one cycle, BUSY=0 -> IDLE.
//  Butterfly mapping, stage s (0..5), k (0..31):
//   - span = 1<<s, grp = k>>s, pos = k & (span-1)
//   - ADDR_A = grp*2*span + pos; ADDR_B = ADDR_A + span (never wraps, <64)
//   - TW_IDX = pos << (5-s), truncated to N_LOG2-1 bits
//  Counter update:
//   - k increments on each issued butterfly.
//   - k=31 -> k=0 and stage+1, with no bubble between stages.
//   - LAST_BF=1 while k=31.
//  Latency: START sampled at edge t0 -> VALID=1, BUSY=1 from t0+1.
//   192 VALID cycles when never stalled (t0+1..t0+192).
//   DONE pulse at t0+193; IDLE at t0+194.
//  STALL:
//   - STALL=1 in RUN -> counters hold; VALID=0 next cycle.
//   - ADDR_A/ADDR_B/TW_IDX/STAGE hold their last values; BUSY stays 1.
//   - STALL deasserted -> next cycle reissues the held butterfly with VALID=1.
//   - Nothing is skipped or duplicated as a VALID beat.
//  STALL during IDLE or FIN has no effect; DONE is never delayed by STALL.
//  START while BUSY or in FIN: ignored, never queued.
//  START held high continuously: a new pass begins from the cycle after IDLE
//   is re-entered, i.e. back-to-back passes with one FIN cycle between them.
//  STAGE values 6 and 7 are never driven; mux inputs D6/D7 are don't-care.
//  Reset asserted mid-pass: immediate return to IDLE, outputs 0, no DONE.
// TESTING
//  1 Reset then START pulse, no stall:
//     - beat0 STAGE=0 A=0 B=1 TW=0; beat1 A=2 B=3 TW=0.
//     - 192 VALID beats; DONE at t0+193.
//  2 Stage checks:
//     - stage1 k=1 -> A=1 B=3 TW=16.
//     - stage3 k=9 -> A=17 B=25 TW=4.
//     - stage5 k=31 -> A=31 B=63 TW=31, LAST_BF=1.
//  3 STALL=1 for 3 cycles at stage2 k=5:
//     - VALID=0 for 3 cycles with outputs frozen at A=9 B=13 TW=8.
//     - Beat resumes, no loss or duplicate; DONE delayed by 3 cycles.
//  4 START pulsed at stage3 mid-pass -> ignored; exactly 192 beats; one DONE.
//  5 RST_N low at stage4 k=10 -> all outputs 0 at once; no DONE.
//     - Later START gives a fresh pass beginning A=0 B=1.
//  6 Scoreboard: over a full pass with random STALL, every (stage, A, B) pair
//     matches the golden radix-2 model.
//     - Each address 0..63 is touched exactly once per stage.

Source files
------------

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: address/control sequencer for a 2**N_LOG2-point radix-2 DIT FFT
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   start           request one full pass; only sampled in IDLE
//   stall           downstream not ready; no butterfly is issued on a stalled edge
//   busy            high from the first issue until the DONE cycle
//   valid           stage/addr_a/addr_b/tw_idx/last_bf describe a live butterfly
//   stage           stage number, drives the per-stage mux select
//   addr_a, addr_b  upper/lower-leg operand addresses (addr_b = addr_a + span)
//   tw_idx          twiddle ROM index
//   last_bf         last butterfly of the current stage (qualified by valid)
//   done            one-cycle pulse after the final butterfly
module fft_stage_sequencer #(
  parameter int N_LOG2    = 6,
  parameter int SEL_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stall,
  output logic                 busy,
  output logic                 valid,
  output logic [SEL_WIDTH-1:0] stage,
  output logic [N_LOG2-1:0]    addr_a,
  output logic [N_LOG2-1:0]    addr_b,
  output logic [N_LOG2-2:0]    tw_idx,
  output logic                 last_bf,
  output logic                 done
);
  localparam int KW = N_LOG2 - 1;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t                state_q, state_d;
  logic [SEL_WIDTH-1:0]  ptr_s_q, ptr_s_d, stage_q, stage_d, cur_s;
  logic [KW-1:0]         ptr_k_q, ptr_k_d, tw_q, tw_d, cur_k, pos, span_m1;
  logic [N_LOG2-1:0]     a_q, a_d, b_q, b_d, span, a_w;
  logic                  busy_q, busy_d, valid_q, valid_d, last_q, last_d, done_q, done_d;
  logic                  issue, all_issued;
  // The pointer {ptr_s, ptr_k} names the next butterfly to issue; stage == N_LOG2
  // marks that every butterfly of the pass has been issued.
  always_comb begin
    cur_s      = (state_q == IDLE) ? '0 : ptr_s_q;
    cur_k      = (state_q == IDLE) ? '0 : ptr_k_q;
    span       = N_LOG2'(1) << cur_s;
    span_m1    = KW'(span - N_LOG2'(1));
    pos        = cur_k & span_m1;
    a_w        = ((N_LOG2'(cur_k) >> cur_s) << (cur_s + 1'b1)) | N_LOG2'(pos);
    all_issued = (ptr_s_q == SEL_WIDTH'(N_LOG2));
    issue      = ((state_q == IDLE) && start) || ((state_q == RUN) && !stall && !all_issued);
    state_d    = state_q;
    ptr_s_d    = ptr_s_q;
    ptr_k_d    = ptr_k_q;
    stage_d    = stage_q;
    a_d        = a_q;
    b_d        = b_q;
    tw_d       = tw_q;
    last_d     = last_q;
    busy_d     = busy_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    if (issue) begin
      state_d            = RUN;
      busy_d             = 1'b1;
      valid_d            = 1'b1;
      stage_d            = cur_s;
      a_d                = a_w;
      b_d                = a_w + span;
      tw_d               = pos << (KW - int'(cur_s));
      last_d             = (cur_k == '1);
      {ptr_s_d, ptr_k_d} = {cur_s, cur_k} + 1'b1;
    end else if ((state_q == RUN) && all_issued) begin
      // Completion ignores stall: the last butterfly has already gone out.
      state_d = FIN;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end else if (state_q != RUN) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_s_q <= '0;
      ptr_k_q <= '0;
      stage_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tw_q    <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_s_q <= ptr_s_d;
      ptr_k_q <= ptr_k_d;
      stage_q <= stage_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tw_q    <= tw_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end
  assign busy    = busy_q;
  assign valid   = valid_q;
  assign stage   = stage_q;
  assign addr_a  = a_q;
  assign addr_b  = b_q;
  assign tw_idx  = tw_q;
  assign last_bf = last_q;
  assign done    = done_q;
endmodule
